// File: rtl/bytes_bits_stream_if.sv
// Byte/bit stream handshake bundle: one input beat channel and one output beat channel.
// master drives beats into the block and consumes its output; slave is the block itself.
interface bytes_bits_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bytes_bits_stream.sv
// Frame-based serializer (mode 0: bytes to LANES-bit beats) and deserializer (mode 1: beats to bytes).
// state | meaning
// IDLE  | waiting for start, no beats accepted
// RUN   | moving beats; holding register shared by both directions
// DONE  | frame complete, done pulse for one cycle
module bytes_bits_stream #(
    parameter int BYTE_COUNT = 256,
    parameter int LANES      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              mode,
    input  logic                              abort,
    bytes_bits_stream_if.slave                stream,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(BYTE_COUNT+1)-1:0]   byte_cnt
);
    localparam int              CW        = $clog2(BYTE_COUNT + 1);
    localparam int              BEATS     = 8 / LANES;
    localparam logic [7:0]      LANE_MASK = 8'((1 << LANES) - 1);
    localparam logic [3:0]      BEAT_LAST = 4'(BEATS - 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(BYTE_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic       mode_q;
    logic       full;
    logic [7:0] shreg;
    logic [3:0] beats_left;
    logic       in_ready_c;
    logic       in_fire, out_fire, byte_fire, last_byte;
    logic [7:0] packed_nx;

    assign in_fire   = stream.in_valid & in_ready_c;
    assign out_fire  = full & stream.out_ready;
    assign byte_fire = out_fire & (mode_q | (beats_left == 4'd0));
    assign last_byte = byte_fire & (byte_cnt == CNT_LAST);

    // Mode 1 fills from the top so the first beat lands at the LSB after BEATS shifts.
    assign packed_nx = (shreg >> LANES) | ((stream.in_data & LANE_MASK) << (8 - LANES));

    assign stream.in_ready  = in_ready_c;
    assign stream.out_valid = full;
    assign stream.out_data  = mode_q ? shreg : (shreg & LANE_MASK);
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                in_ready_c = ~full;
                if (abort)          state_nx = IDLE;
                else if (last_byte) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            full       <= 1'b0;
            shreg      <= 8'h00;
            beats_left <= 4'd0;
            byte_cnt   <= '0;
        end else if (state == IDLE && start) begin
            mode_q     <= mode;
            full       <= 1'b0;
            shreg      <= 8'h00;
            beats_left <= BEAT_LAST;
            byte_cnt   <= '0;
        end else if (state == RUN && abort) begin
            full       <= 1'b0;
            shreg      <= 8'h00;
            beats_left <= BEAT_LAST;
        end else if (state == RUN) begin
            if (in_fire) begin
                if (!mode_q) begin
                    shreg      <= stream.in_data;
                    full       <= 1'b1;
                    beats_left <= BEAT_LAST;
                end else begin
                    shreg <= packed_nx;
                    if (beats_left == 4'd0) begin
                        full       <= 1'b1;
                        beats_left <= BEAT_LAST;
                    end else begin
                        beats_left <= beats_left - 4'd1;
                    end
                end
            end
            if (out_fire) begin
                if (!mode_q) begin
                    shreg <= shreg >> LANES;
                    if (beats_left == 4'd0) full <= 1'b0;
                    else                    beats_left <= beats_left - 4'd1;
                end else begin
                    full <= 1'b0;
                end
            end
            if (byte_fire) byte_cnt <= byte_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_bytes_bits_stream.sv
// Directed bench for bytes_bits_stream: reset, serialize, deserialize, backpressure, abort, round trip.
module tb_bytes_bits_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bytes_bits_stream_if ia();
    bytes_bits_stream_if ib();
    bytes_bits_stream_if ic();
    bytes_bits_stream_if id();
    bytes_bits_stream_if ie();

    logic start_a = 0, start_b = 0, start_c = 0, start_d = 0, start_e = 0;
    logic mode_a = 0, mode_b = 0, mode_c = 0, mode_d = 0, mode_e = 0;
    logic abort_a = 0;
    logic busy_a, busy_b, busy_c, busy_d, busy_e;
    logic done_a, done_b, done_c, done_d, done_e;
    logic [8:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       cnt_d, cnt_e;
    logic chain = 0, a_or = 0;

    assign ia.out_ready = chain ? ib.in_ready : a_or;
    assign ib.in_valid  = chain & ia.out_valid;
    assign ib.in_data   = ia.out_data;

    bytes_bits_stream #(.BYTE_COUNT(256), .LANES(1)) u_a (.clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
        .abort(abort_a), .stream(ia), .busy(busy_a), .done(done_a), .byte_cnt(cnt_a));
    bytes_bits_stream #(.BYTE_COUNT(256), .LANES(1)) u_b (.clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .abort(1'b0), .stream(ib), .busy(busy_b), .done(done_b), .byte_cnt(cnt_b));
    bytes_bits_stream #(.BYTE_COUNT(2), .LANES(1)) u_c (.clk(clk), .rst(rst), .start(start_c), .mode(mode_c),
        .abort(1'b0), .stream(ic), .busy(busy_c), .done(done_c), .byte_cnt(cnt_c));
    bytes_bits_stream #(.BYTE_COUNT(1), .LANES(4)) u_d (.clk(clk), .rst(rst), .start(start_d), .mode(mode_d),
        .abort(1'b0), .stream(id), .busy(busy_d), .done(done_d), .byte_cnt(cnt_d));
    bytes_bits_stream #(.BYTE_COUNT(1), .LANES(2)) u_e (.clk(clk), .rst(rst), .start(start_e), .mode(mode_e),
        .abort(1'b0), .stream(ie), .busy(busy_e), .done(done_e), .byte_cnt(cnt_e));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  cb [2];
    logic [7:0]  eb [4];
    logic [7:0]  rb [256];
    logic [15:0] bits;
    logic [6:0]  upper;
    logic [3:0]  pat;
    logic        acc;
    int          idx, nb, dn, da, db, n;

    initial begin
        ia.in_valid = 0; ia.in_data = 0;
        ib.out_ready = 0;
        ic.in_valid = 0; ic.in_data = 0; ic.out_ready = 0;
        id.in_valid = 0; id.in_data = 0; id.out_ready = 0;
        ie.in_valid = 0; ie.in_data = 0; ie.out_ready = 0;

        // power-on reset
        repeat (3) tick();
        chk("por_busy", busy_a, 0);
        chk("por_out_valid", ia.out_valid, 0);
        chk("por_in_ready", ia.in_ready, 0);
        chk("por_cnt", cnt_a, 0);
        rst = 0;
        tick();

        // reset mid-frame at byte_cnt=3
        start_a = 1; mode_a = 0; a_or = 1;
        tick();
        start_a = 0; ia.in_valid = 1; ia.in_data = 8'h3C;
        n = 0;
        while (cnt_a != 9'd3 && n < 200) begin tick(); n++; end
        chk("rst_reach_cnt3", cnt_a, 3);
        rst = 1;
        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        chk("rst_out_data", ia.out_data, 0);
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cnt", cnt_a, 0);
        tick();
        rst = 0; ia.in_valid = 0;
        dn = 0;
        repeat (20) begin dn += int'(done_a); tick(); end
        chk("rst_no_done", dn, 0);
        chk("rst_idle_busy", busy_a, 0);

        // mode 0, LANES=1: A5, 01 serialized LSB first; start with in_valid high is not an accept
        cb[0] = 8'hA5; cb[1] = 8'h01;
        start_c = 1; mode_c = 0; ic.in_valid = 1; ic.in_data = cb[0]; ic.out_ready = 1;
        chk("c_idle_in_ready", ic.in_ready, 0);
        tick();
        start_c = 0;
        idx = 0; nb = 0; dn = 0; bits = 0; upper = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            acc = ic.in_valid & ic.in_ready;
            if (ic.out_valid && ic.out_ready) begin
                if (nb < 16) bits[nb] = ic.out_data[0];
                upper |= ic.out_data[7:1];
                nb++;
            end
            dn += int'(done_c);
            tick();
            if (acc) begin
                idx++;
                ic.in_valid = (idx < 2);
                ic.in_data  = cb[(idx < 2) ? idx : 1];
            end
        end
        chk("c_bits", bits, 16'h01A5);
        chk("c_beats", nb, 16);
        chk("c_upper_zero", upper, 0);
        chk("c_done_pulses", dn, 1);
        chk("c_byte_cnt", cnt_c, 2);
        chk("c_busy_end", busy_c, 0);

        // mode 1, LANES=4: nibbles 5 then A pack to A5
        start_d = 1; mode_d = 1;
        tick();
        start_d = 0;
        chk("d_in_ready", id.in_ready, 1);
        id.in_valid = 1; id.in_data = 8'h05;
        tick();
        chk("d_partial_valid", id.out_valid, 0);
        id.in_data = 8'h0A;
        tick();
        chk("d_out_valid", id.out_valid, 1);
        chk("d_out_data", id.out_data, 8'hA5);
        chk("d_in_ready_full", id.in_ready, 0);
        id.in_valid = 0; id.out_ready = 0;
        tick();
        chk("d_hold_valid", id.out_valid, 1);
        chk("d_hold_data", id.out_data, 8'hA5);
        id.out_ready = 1;
        tick();
        chk("d_done", done_d, 1);
        chk("d_byte_cnt", cnt_d, 1);
        chk("d_valid_drop", id.out_valid, 0);
        id.out_ready = 0;
        tick();
        chk("d_done_once", done_d, 0);
        chk("d_busy_end", busy_d, 0);

        // mode 0, LANES=2 with out_ready pattern 1,0,0,1: 0x1B -> 3,2,1,0
        eb[0] = 8'd3; eb[1] = 8'd2; eb[2] = 8'd1; eb[3] = 8'd0;
        pat = 4'b1001;
        start_e = 1; mode_e = 0; ie.in_valid = 1; ie.in_data = 8'h1B;
        tick();
        start_e = 0;
        nb = 0; dn = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            ie.out_ready = pat[cyc % 4];
            acc = ie.in_valid & ie.in_ready;
            if (ie.out_valid) begin
                if (nb < 4) chk("e_beat", ie.out_data, eb[nb]);
                if (ie.out_ready) nb++;
            end
            dn += int'(done_e);
            tick();
            if (acc) ie.in_valid = 0;
        end
        chk("e_beats", nb, 4);
        chk("e_done_pulses", dn, 1);

        // abort at byte_cnt=100
        chain = 0; a_or = 1;
        start_a = 1; mode_a = 0;
        tick();
        start_a = 0; ia.in_valid = 1; ia.in_data = 8'h5A;
        n = 0; dn = 0;
        while (cnt_a != 9'd100 && n < 3000) begin dn += int'(done_a); tick(); n++; end
        chk("ab_reach_cnt100", cnt_a, 100);
        abort_a = 1;
        tick();
        abort_a = 0; ia.in_valid = 0;
        chk("ab_busy", busy_a, 0);
        chk("ab_out_valid", ia.out_valid, 0);
        chk("ab_in_ready", ia.in_ready, 0);
        repeat (10) begin dn += int'(done_a); tick(); end
        chk("ab_no_done", dn, 0);

        // round trip: u_a (mode 0) feeds u_b (mode 1), 256 random bytes
        for (int i = 0; i < 256; i++) rb[i] = 8'($urandom);
        chain = 1; ib.out_ready = 1;
        start_a = 1; mode_a = 0; start_b = 1; mode_b = 1;
        tick();
        start_a = 0; start_b = 0;
        idx = 0; nb = 0; da = 0; db = 0;
        ia.in_valid = 1; ia.in_data = rb[0];
        for (int cyc = 0; cyc < 6000; cyc++) begin
            acc = ia.in_valid & ia.in_ready;
            if (ib.out_valid && ib.out_ready) begin
                if (nb < 256) chk("rt_byte", ib.out_data, rb[nb]);
                nb++;
            end
            da += int'(done_a);
            db += int'(done_b);
            tick();
            if (acc) begin
                idx++;
                if (idx < 256) ia.in_data = rb[idx];
                else           ia.in_valid = 0;
            end
            ib.out_ready = 1'($urandom_range(0, 1));
        end
        chk("rt_count", nb, 256);
        chk("rt_done_a", da, 1);
        chk("rt_done_b", db, 1);
        chk("rt_cnt_a", cnt_a, 256);
        chk("rt_cnt_b", cnt_b, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bytes_bits_stream.md
BYTES_BITS_STREAM -- requirements
Module: bytes_bits_stream

Interface
REQ-001 SHALL have parameter BYTE_COUNT, default 256, giving the bytes per frame (>=1).
REQ-002 SHALL have parameter LANES, default 1, giving the bits per bit-side beat; legal values are 1, 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a frame when sampled high in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = BytesToBits, 1 = BitsToBytes; sampled only with start.
REQ-007 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-008 SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the input beat.
REQ-010 SHALL have port in_data, input, 8 bits: a byte (mode 0) or bits in [LANES-1:0] (mode 1).
REQ-011 SHALL have port out_valid, output, 1 bit: the output beat is present.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-013 SHALL have port out_data, output, 8 bits: bits in [LANES-1:0] with upper bits 0 (mode 0), or a byte (mode 1).
REQ-014 SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-016 SHALL have port byte_cnt, output, $clog2(BYTE_COUNT+1) bits: bytes completed in the current frame.

Function
REQ-017 SHALL use FSM states IDLE, RUN and DONE.
REQ-018 SHALL go IDLE->RUN on start=1, latch mode and clear byte_cnt; start SHALL be ignored outside IDLE.
REQ-019 SHALL hold in_ready=0 in IDLE and DONE; in RUN, in_ready=1 only when the holding register is empty; there is no combinational path from out_ready to in_ready.
REQ-020 SHALL, in mode 0, load an accepted byte into the shift register and assert out_valid on the next cycle, with no input-to-output combinational path.
REQ-021 SHALL, in mode 0, output bit 8i+j = (byte_i >> j) & 1, LSB first, LANES bits per beat, and take 8/LANES handshakes per byte.
REQ-022 SHALL, in mode 0, shift right by LANES on each out handshake; the register SHALL be empty after the last beat of a byte, giving one idle cycle before the next in_ready.
REQ-023 SHALL, in mode 1, pack accepted beats LSB first, so byte = sum over beats k of in_data[LANES-1:0] << (k*LANES).
REQ-024 SHALL, in mode 1, assert out_valid on the cycle after the (8/LANES)th beat and hold in_ready=0 until the byte is handshaken.
REQ-025 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL increment byte_cnt on each completed byte: the last-beat out handshake in mode 0, the byte out handshake in mode 1.
REQ-027 SHALL, when byte_cnt reaches BYTE_COUNT, accept no further input and go RUN->DONE; DONE asserts done=1 for one cycle, then the FSM returns to IDLE with busy=0 in that IDLE cycle.
REQ-028 SHALL hold byte_cnt at BYTE_COUNT after completion until the next start; it SHALL never wrap.
REQ-029 SHALL, when start and in_valid are both high in IDLE, not accept the input beat in that cycle.
REQ-030 SHALL, on abort=1 in RUN, return to IDLE next cycle, discard partial data, drop out_valid and produce no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-031 SHALL give abort priority when abort coincides with the final handshake: no done pulse.

Reset
REQ-032 SHALL, with rst=1, immediately force state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, byte_cnt=0 and latched mode=0, regardless of clk.
REQ-033 SHALL, if rst asserts mid-frame, lose all partial data; after release, the block waits for a new start.

Verification
REQ-034 SHALL check reset: rst pulsed mid-frame (mode 0, byte_cnt=3) -> all outputs 0 within the same cycle; no done after release.
REQ-035 SHALL check mode 0 with LANES=1, BYTE_COUNT=2: bytes 0xA5, 0x01 -> bits 1,0,1,0,0,1,0,1,1,0,0,0,0,0,0,0, then one done pulse and byte_cnt=2.
REQ-036 SHALL check mode 1 with LANES=4, BYTE_COUNT=1: nibbles 0x5 then 0xA -> out_data=0xA5 one cycle after the second beat; done follows the handshake.
REQ-037 SHALL check backpressure: mode 0 with LANES=2 on byte 0x1B and out_ready toggling 1,0,0,1... -> beats 3,2,1,0 (3,2,1,0 is 0x1B split LSB first), each held stable while stalled.
REQ-038 SHALL check round trip with BYTE_COUNT=256, LANES=1, random bytes: mode 0 output fed to mode 1 -> identical 256 bytes, with exactly one done per frame.
REQ-039 SHALL check abort: abort=1 at byte_cnt=100 -> IDLE next cycle, out_valid=0, no done; a following start runs a full frame normally.
